// File: rtl/mips_cpu_muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide unit: operation codes and FSM states.
package mips_cpu_muldiv_pkg;

  localparam int DATA_W_DEFAULT = 32;

  typedef enum logic [2:0] {
    NOP   = 3'd0,
    MULT  = 3'd1,
    MULTU = 3'd2,
    DIV   = 3'd3,
    DIVU  = 3'd4,
    MTHI  = 3'd5,
    MTLO  = 3'd6
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } muldiv_state_t;

  function automatic logic is_signed_op(input muldiv_op_t op);
    return (op == MULT) || (op == DIV);
  endfunction

endpackage

// File: rtl/mips_cpu_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module mips_cpu_div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_i,
  input  logic              dividend_bit_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W-1:0] rem_o,
  output logic              q_bit_o
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;

  assign shifted = {rem_i, dividend_bit_i};
  assign diff    = shifted - {1'b0, divisor_i};
  // Partial remainder stays below the divisor, so the top bit of diff is a clean borrow flag.
  assign q_bit_o = ~diff[DATA_W];
  assign rem_o   = q_bit_o ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];

endmodule

// File: rtl/mips_cpu_muldiv.sv
// Multi-cycle MULT/DIV unit owning HI/LO; magnitudes are iterated, signs applied in FIX.
module mips_cpu_muldiv
  import mips_cpu_muldiv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  muldiv_op_t        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int CNT_W = $clog2(DATA_W);

  muldiv_state_t       state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0]   opnd_q, hi_q, lo_q;
  logic                is_div_q, neg_q, sign_a_q, div0_q, done_q;

  logic                a_neg, b_neg;
  logic [DATA_W-1:0]   a_mag, b_mag;
  logic [DATA_W:0]     mul_sum;
  logic [DATA_W-1:0]   div_rem;
  logic                div_qbit;
  logic [DATA_W-1:0]   fix_hi, fix_lo;

  always_comb begin
    a_neg = is_signed_op(op) & a[DATA_W-1];
    b_neg = is_signed_op(op) & b[DATA_W-1];
    a_mag = a_neg ? (~a + 1'b1) : a;
    b_mag = b_neg ? (~b + 1'b1) : b;
  end

  mips_cpu_div_step #(.DATA_W(DATA_W)) u_div_step (
    .rem_i          (acc_q[2*DATA_W-1:DATA_W]),
    .dividend_bit_i (acc_q[DATA_W-1]),
    .divisor_i      (opnd_q),
    .rem_o          (div_rem),
    .q_bit_o        (div_qbit)
  );

  // acc_q is {product high, multiplier} for multiply and {remainder, dividend/quotient} for divide.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    if (is_div_q) acc_d = {div_rem, acc_q[DATA_W-2:0], div_qbit};
    else          acc_d = {mul_sum, acc_q[DATA_W-1:1]};
  end

  always_comb begin
    fix_hi = '0;
    fix_lo = '0;
    if (is_div_q) begin
      if (div0_q)     fix_lo = '1;
      else if (neg_q) fix_lo = ~acc_q[DATA_W-1:0] + 1'b1;
      else            fix_lo = acc_q[DATA_W-1:0];
      fix_hi = sign_a_q ? (~acc_q[2*DATA_W-1:DATA_W] + 1'b1) : acc_q[2*DATA_W-1:DATA_W];
    end else begin
      {fix_hi, fix_lo} = neg_q ? (~acc_q + 1'b1) : acc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      sign_a_q <= 1'b0;
      div0_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            case (op)
              MULT, MULTU, DIV, DIVU: begin
                state_q  <= RUN;
                cnt_q    <= CNT_W'(DATA_W - 1);
                is_div_q <= (op == DIV) || (op == DIVU);
                neg_q    <= a_neg ^ b_neg;
                sign_a_q <= a_neg;
                div0_q   <= (b == '0);
                if ((op == DIV) || (op == DIVU)) begin
                  acc_q  <= {{DATA_W{1'b0}}, a_mag};
                  opnd_q <= b_mag;
                end else begin
                  acc_q  <= {{DATA_W{1'b0}}, b_mag};
                  opnd_q <= a_mag;
                end
              end
              MTHI:    hi_q <= a;
              MTLO:    lo_q <= a;
              default: ;
            endcase
          end
        end
        RUN: begin
          acc_q <= acc_d;
          if (cnt_q == '0) state_q <= FIX;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        FIX: begin
          hi_q    <= fix_hi;
          lo_q    <= fix_lo;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Directed bench for mips_cpu_muldiv: vector table plus MTHI/MTLO, ignored-start and reset-abort sequences.
module tb_mips_cpu_muldiv;
  import mips_cpu_muldiv_pkg::*;

  logic        clk, reset, start;
  muldiv_op_t  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] m_hi, m_lo;

  typedef struct {
    muldiv_op_t  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[12];

  mips_cpu_muldiv #(.DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end else begin
      $display("ok   %s value=%h", name, act);
    end
  endtask

  // Issue one MULT/DIV; inj>0 pulses an MTLO request in that busy cycle, which must be ignored.
  task automatic do_op(input string name, input muldiv_op_t o, input logic [31:0] av,
                       input logic [31:0] bv, input logic [31:0] eh, input logic [31:0] el,
                       input int inj);
    logic ok;
    ok = 1'b1;
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    for (int cyc = 1; cyc <= 34; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin start = 1'b0; op = NOP; end
      if (cyc <= 33) begin
        if (busy !== 1'b1 || done !== 1'b0 || hi !== m_hi || lo !== m_lo) ok = 1'b0;
      end else begin
        if (busy !== 1'b0 || done !== 1'b1) ok = 1'b0;
      end
      if (inj != 0 && cyc == inj) begin start = 1'b1; op = MTLO; a = 32'h5555AAAA; end
      if (inj != 0 && cyc == inj + 1) begin start = 1'b0; op = NOP; end
    end
    chk({name, "_timing"}, {31'd0, ok}, 32'd1);
    chk({name, "_hi"}, hi, eh);
    chk({name, "_lo"}, lo, el);
    m_hi = eh;
    m_lo = el;
    @(negedge clk);
    chk({name, "_done_drop"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic saw_done;
    vecs[0]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2]  = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[3]  = '{DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4]  = '{DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
    vecs[5]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[6]  = '{DIVU,  32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF};
    vecs[7]  = '{DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[8]  = '{DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[9]  = '{MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
    vecs[10] = '{DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003};
    vecs[11] = '{MULT,  32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFB};

    reset = 1'b1; start = 1'b0; op = NOP; a = '0; b = '0;
    m_hi = '0; m_lo = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b0;

    // MTHI then MTLO on back-to-back cycles.
    @(negedge clk);
    start = 1'b1; op = MTHI; a = 32'hDEADBEEF;
    @(negedge clk);
    chk("mthi_hi", hi, 32'hDEADBEEF);
    chk("mthi_lo", lo, 32'h0);
    chk("mthi_busy_done", {30'd0, busy, done}, 32'd0);
    op = MTLO; a = 32'h00000001;
    @(negedge clk);
    start = 1'b0; op = NOP;
    chk("mtlo_lo", lo, 32'h00000001);
    chk("mtlo_hi", hi, 32'hDEADBEEF);
    chk("mtlo_busy_done", {30'd0, busy, done}, 32'd0);
    m_hi = 32'hDEADBEEF; m_lo = 32'h00000001;

    // NOP and reserved opcode with start are no-ops.
    @(negedge clk);
    start = 1'b1; op = muldiv_op_t'(3'd7); a = 32'h11111111; b = 32'h22222222;
    @(negedge clk);
    op = NOP;
    chk("rsvd_hilo", hi ^ lo, m_hi ^ m_lo);
    chk("rsvd_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    chk("nop_hi", hi, m_hi);
    chk("nop_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 12; i++) begin
      do_op($sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, 0);
    end

    // MTLO strobe during an in-flight DIVU: 100/7 = 14 rem 2.
    do_op("divu_mtlo_ign", DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 5);

    // Reset in cycle 10 of a DIV aborts it.
    @(negedge clk);
    start = 1'b1; op = DIV; a = 32'hFFFFFF00; b = 32'd3;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin start = 1'b0; op = NOP; end
      if (cyc == 10) reset = 1'b1;
    end
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    m_hi = '0; m_lo = '0;
    saw_done = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    chk("abort_no_done", {31'd0, saw_done}, 32'd0);
    do_op("post_rst_multu", MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
